cam_stream_tx: RTL

Camera-side stream transmitter: reads a 12-bit RGB444 frame from the dual-port frame buffer and replays it as an OV7670-style parallel stream (VSYNC, HREF, two bytes per pixel). It is the sending end of the capture path and is used in simulation benches and in loopback builds to drive the capture block without a physical camera. It can also emit a built-in ramp pattern instead of RAM contents.

---
 rtl/cam_pkg.sv | 21 ++
 rtl/cam_stream_tx_if.sv | 27 ++
 rtl/cam_tx_timing.sv | 111 +++++++++++
 rtl/cam_stream_tx.sv | 92 +++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared camera-path definitions: FSM encoding, RGB444 pixel format and default frame geometry.
package cam_pkg;

  typedef enum logic [2:0] {IDLE, VS, VBP, ACT, HBL, VFP} cam_state_t;

  localparam int PIX_W     = 12;
  localparam int DEF_H_PIX = 160;
  localparam int DEF_V_PIX = 120;

  typedef logic [PIX_W-1:0] pixel_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wire order on the camera bus: high nibble first (zero-padded), then the low byte.
  function automatic logic [7:0] px_byte(input pixel_t p, input logic second);
    return second ? p[7:0] : {4'h0, p[11:8]};
  endfunction

endpackage

// File: rtl/cam_stream_tx_if.sv
// Transmitter-side bus: synchronous frame-buffer read port plus the OV7670-style parallel stream.
interface cam_stream_tx_if #(parameter int AW = 15);
  import cam_pkg::*;

  logic [AW-1:0] DP_RAM_addr_out;
  pixel_t        DP_RAM_data_out;
  logic          CAM_VSYNC;
  logic          CAM_HREF;
  logic [7:0]    CAM_px_data;

  modport master (
    output DP_RAM_addr_out,
    input  DP_RAM_data_out,
    output CAM_VSYNC,
    output CAM_HREF,
    output CAM_px_data
  );

  modport slave (
    input  DP_RAM_addr_out,
    output DP_RAM_data_out,
    input  CAM_VSYNC,
    input  CAM_HREF,
    input  CAM_px_data
  );

endinterface

// File: rtl/cam_tx_timing.sv
// Frame/line sequencer: state, position counters, registered VSYNC/HREF/busy/frame_done.
// Also exposes next-cycle (x, y) and byte phase so the datapath can register bytes in step with HREF.
module cam_tx_timing
  import cam_pkg::*;
#(
  parameter int H_PIX   = DEF_H_PIX,
  parameter int V_PIX   = DEF_V_PIX,
  parameter int H_BLANK = 16,
  parameter int V_SYNC  = 3,
  parameter int V_BACK  = 2,
  parameter int V_FRONT = 2,
  localparam int XW     = idx_w(H_PIX),
  localparam int YW     = idx_w(V_PIX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic          act_nxt,
  output logic          second_nxt,
  output logic          vs_entry,
  output logic [XW-1:0] px_x,
  output logic [YW-1:0] px_y,
  output logic          vsync,
  output logic          href,
  output logic          frame_done,
  output logic          busy
);

  localparam int L       = 2 * H_PIX + H_BLANK;
  localparam int ACT_LEN = 2 * H_PIX;
  localparam int V_MAX   = (V_SYNC > V_BACK) ? ((V_SYNC > V_FRONT) ? V_SYNC : V_FRONT)
                                             : ((V_BACK > V_FRONT) ? V_BACK : V_FRONT);
  localparam int CW      = idx_w(V_MAX * L);

  cam_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, last_cnt;
  logic [YW-1:0] line, line_nxt;
  logic          run_q;

  always_comb begin
    last_cnt = '0;
    case (state)
      VS:      last_cnt = CW'(V_SYNC * L - 1);
      VBP:     last_cnt = CW'(V_BACK * L - 1);
      ACT:     last_cnt = CW'(ACT_LEN - 1);
      HBL:     last_cnt = CW'(H_BLANK - 1);
      VFP:     last_cnt = CW'(V_FRONT * L - 1);
      default: last_cnt = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    line_nxt  = line;
    if (state == IDLE) begin
      cnt_nxt = '0;
      if (run_q) state_nxt = VS;
    end else if (cnt == last_cnt) begin
      cnt_nxt = '0;
      case (state)
        VS:  state_nxt = VBP;
        VBP: begin
          state_nxt = ACT;
          line_nxt  = '0;
        end
        ACT: state_nxt = HBL;
        HBL: begin
          if (line != YW'(V_PIX - 1)) begin
            state_nxt = ACT;
            line_nxt  = line + 1'b1;
          end else begin
            state_nxt = VFP;
          end
        end
        VFP:     state_nxt = run_q ? VS : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign act_nxt    = (state_nxt == ACT);
  assign second_nxt = cnt_nxt[0];
  assign vs_entry   = (state_nxt == VS) && (state != VS);
  assign px_x       = XW'(cnt_nxt >> 1);
  assign px_y       = line_nxt;

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      line       <= '0;
      run_q      <= 1'b0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      line       <= line_nxt;
      run_q      <= run;
      vsync      <= (state_nxt == VS);
      href       <= (state_nxt == ACT);
      busy       <= (state_nxt != IDLE);
      frame_done <= (state_nxt == VFP) && (cnt_nxt == CW'(V_FRONT * L - 1));
    end
  end

endmodule

// File: rtl/cam_stream_tx.sv
// Camera stream transmitter: replays an RGB444 frame (or a ramp) as VSYNC/HREF plus two bytes per pixel.
// Datapath: read-address generator, pixel prefetch register, pattern mux and byte serializer.
module cam_stream_tx
  import cam_pkg::*;
#(
  parameter int AW      = 15,
  parameter int H_PIX   = DEF_H_PIX,
  parameter int V_PIX   = DEF_V_PIX,
  parameter int H_BLANK = 16,
  parameter int V_SYNC  = 3,
  parameter int V_BACK  = 2,
  parameter int V_FRONT = 2
) (
  input  logic            CAM_PCLK,
  input  logic            rst,
  input  logic            run,
  input  logic            pattern_sel,
  cam_stream_tx_if.master bus,
  output logic            frame_done,
  output logic            busy
);

  localparam int XW = idx_w(H_PIX);
  localparam int YW = idx_w(V_PIX);

  logic          act_nxt, second_nxt, vs_entry;
  logic          vsync, href;
  logic [XW-1:0] px_x;
  logic [YW-1:0] px_y;
  logic          last_px;
  logic [AW-1:0] addr;
  logic          pat_q;
  pixel_t        pix_q, cur_pix;
  logic [7:0]    px_dat;

  cam_tx_timing #(
    .H_PIX   (H_PIX),
    .V_PIX   (V_PIX),
    .H_BLANK (H_BLANK),
    .V_SYNC  (V_SYNC),
    .V_BACK  (V_BACK),
    .V_FRONT (V_FRONT)
  ) u_timing (
    .clk        (CAM_PCLK),
    .rst        (rst),
    .run        (run),
    .act_nxt    (act_nxt),
    .second_nxt (second_nxt),
    .vs_entry   (vs_entry),
    .px_x       (px_x),
    .px_y       (px_y),
    .vsync      (vsync),
    .href       (href),
    .frame_done (frame_done),
    .busy       (busy)
  );

  assign last_px = (px_x == XW'(H_PIX - 1)) && (px_y == YW'(V_PIX - 1));

  // addr still names the pixel being emitted when its first byte is registered, so it doubles as the ramp value.
  assign cur_pix = pat_q ? PIX_W'(addr) : bus.DP_RAM_data_out;

  // addr moves to pixel n+1 on pixel n's first-byte edge: two clocks ahead of its use (RAM latency + output reg).
  always_ff @(posedge CAM_PCLK) begin
    if (rst) begin
      addr   <= '0;
      pat_q  <= 1'b0;
      pix_q  <= '0;
      px_dat <= '0;
    end else begin
      if (vs_entry) begin
        addr  <= '0;
        pat_q <= pattern_sel;
      end
      if (act_nxt && !second_nxt) begin
        px_dat <= px_byte(cur_pix, 1'b0);
        pix_q  <= cur_pix;
        if (!last_px) addr <= addr + 1'b1;
      end else if (act_nxt) begin
        px_dat <= px_byte(pix_q, 1'b1);
      end else begin
        px_dat <= '0;
      end
    end
  end

  assign bus.DP_RAM_addr_out = addr;
  assign bus.CAM_VSYNC       = vsync;
  assign bus.CAM_HREF        = href;
  assign bus.CAM_px_data     = px_dat;

endmodule
